// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: keeps one imem request in flight, parks a response in a
// one-entry skid register while downstream stalls, and flushes on a PC redirect.
module instr_fetch_unit #(
   parameter logic [7:0]  RESET_PC = 8'h00,
   parameter logic [15:0] NOP_WORD = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [7:0]  imem_addr,
   input  logic        imem_valid,
   input  logic [15:0] imem_rdata,
   input  logic        stall,
   input  logic        L_PC,
   input  logic        S11,
   input  logic        S10,
   input  logic [7:0]  OR2,
   input  logic [7:0]  NPC_in,
   input  logic [7:0]  dm_data,
   output logic [15:0] segment,
   output logic [7:0]  PC_in,
   output logic        seg_valid
);

   localparam int unsigned AW = 8;
   localparam int unsigned DW = 16;

   typedef enum logic [1:0] {
      ISSUE = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2,
      DROP  = 2'd3
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [AW-1:0] pc;
   logic [AW-1:0] pc_nxt;
   logic [AW-1:0] pc_inc;
   logic [AW-1:0] target;
   logic [DW-1:0] skid;
   logic [DW-1:0] skid_nxt;
   logic          skid_full;
   logic          skid_full_nxt;
   logic [DW-1:0] segment_nxt;
   logic [AW-1:0] pc_in_nxt;
   logic          seg_valid_nxt;

   assign pc_inc = AW'(pc + 1'b1);

   // Redirect target selection; the relative form wraps modulo 256.
   always_comb begin
      target = NPC_in;
      unique case ({S11, S10})
         2'b01:   target = AW'(NPC_in + OR2);
         2'b11:   target = OR2;
         2'b10:   target = dm_data;
         default: target = NPC_in;
      endcase
   end

   // A redirect in ISSUE suppresses the request so the old address never reaches memory.
   assign imem_req  = (state == ISSUE) && !rst && !L_PC;
   assign imem_addr = rst ? RESET_PC : pc;

   // Next-state and datapath update.
   always_comb begin
      state_nxt     = state;
      pc_nxt        = pc;
      segment_nxt   = segment;
      pc_in_nxt     = PC_in;
      seg_valid_nxt = seg_valid;
      skid_nxt      = skid;
      skid_full_nxt = skid_full;

      case (state)
         ISSUE: begin
            state_nxt = WAIT;
         end
         WAIT: begin
            if (imem_valid) begin
               if (!stall) begin
                  segment_nxt   = imem_rdata;
                  pc_in_nxt     = pc_inc;
                  seg_valid_nxt = 1'b1;
                  pc_nxt        = pc_inc;
                  state_nxt     = ISSUE;
               end else begin
                  skid_nxt      = imem_rdata;
                  skid_full_nxt = 1'b1;
                  state_nxt     = HOLD;
               end
            end
         end
         HOLD: begin
            if (!skid_full) begin
               state_nxt = ISSUE;
            end else if (!stall) begin
               segment_nxt   = skid;
               pc_in_nxt     = pc_inc;
               seg_valid_nxt = 1'b1;
               pc_nxt        = pc_inc;
               skid_full_nxt = 1'b0;
               state_nxt     = ISSUE;
            end
         end
         DROP: begin
            if (imem_valid) begin
               state_nxt = ISSUE;
            end
         end
         default: begin
            state_nxt = ISSUE;
         end
      endcase

      // Redirect overrides stall and any response arriving this cycle.
      if (L_PC) begin
         pc_nxt        = target;
         segment_nxt   = NOP_WORD;
         seg_valid_nxt = 1'b0;
         skid_full_nxt = 1'b0;
         if (((state == WAIT) || (state == DROP)) && !imem_valid) begin
            state_nxt = DROP;
         end else begin
            state_nxt = ISSUE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ISSUE;
         pc        <= RESET_PC;
         segment   <= NOP_WORD;
         PC_in     <= RESET_PC;
         seg_valid <= 1'b0;
         skid      <= '0;
         skid_full <= 1'b0;
      end else begin
         state     <= state_nxt;
         pc        <= pc_nxt;
         segment   <= segment_nxt;
         PC_in     <= pc_in_nxt;
         seg_valid <= seg_valid_nxt;
         skid      <= skid_nxt;
         skid_full <= skid_full_nxt;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: behavioural memory, directed scenarios, then random
// stall/redirect traffic checked by a scoreboard of expected fetch addresses.
module tb_instr_fetch_unit;

   localparam logic [7:0]  RST_PC = 8'h00;
   localparam logic [15:0] NOP    = 16'h0000;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_valid;
   logic [15:0] imem_rdata;
   logic        stall;
   logic        L_PC;
   logic        S11;
   logic        S10;
   logic [7:0]  OR2;
   logic [7:0]  NPC_in;
   logic [7:0]  dm_data;
   logic [15:0] segment;
   logic [7:0]  PC_in;
   logic        seg_valid;

   instr_fetch_unit #(.RESET_PC(RST_PC), .NOP_WORD(NOP)) dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_valid(imem_valid), .imem_rdata(imem_rdata), .stall(stall),
      .L_PC(L_PC), .S11(S11), .S10(S10), .OR2(OR2), .NPC_in(NPC_in),
      .dm_data(dm_data), .segment(segment), .PC_in(PC_in), .seg_valid(seg_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int failures = 0;
   int n_instr = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void fail_now(string name);
      checks++;
      failures++;
      $display("FAIL %s (bound expired or missing expectation) at %0t", name, $time);
   endfunction

   // Memory model: fixed or random latency, one response per request.
   logic [15:0] mem [256];
   int          mem_cnt = 0;
   logic [7:0]  mem_addr = 8'h00;
   int          lat_fix = 1;

   always @(negedge clk) begin
      if (imem_req === 1'b1) begin
         chk("one_outstanding", 32'(mem_cnt), 32'd0);
         mem_addr = imem_addr;
         mem_cnt  = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 3));
      end
   end

   always @(posedge clk) begin
      #1;
      imem_valid = 1'b0;
      imem_rdata = 16'($urandom);
      if (mem_cnt > 0) begin
         mem_cnt--;
         if (mem_cnt == 0) begin
            imem_valid = 1'b1;
            imem_rdata = mem[mem_addr];
         end
      end
   end

   // Redirect target computed straight from the selection rule.
   function automatic logic [7:0] ref_target(logic [1:0] sel, logic [7:0] npc,
                                             logic [7:0] or2, logic [7:0] dm);
      int t;
      case (sel)
         2'b01:   t = (int'(npc) + int'(or2)) % 256;
         2'b11:   t = int'(or2);
         2'b10:   t = int'(dm);
         default: t = int'(npc);
      endcase
      return 8'(t);
   endfunction

   logic [7:0] redir_q [$];

   task automatic do_redirect(logic [1:0] sel, logic [7:0] npc, logic [7:0] or2, logic [7:0] dm);
      L_PC    = 1'b1;
      S11     = sel[1];
      S10     = sel[0];
      NPC_in  = npc;
      OR2     = or2;
      dm_data = dm;
      redir_q.push_back(ref_target(sel, npc, or2, dm));
   endtask

   // Monitor: every newly presented instruction must be the next sequential
   // fetch from the last redirect target; stalls hold, redirects flush.
   logic [7:0]  exp_addr = RST_PC;
   logic        flush_pend = 1'b0;
   logic        have_prev = 1'b0;
   logic        p_stall, p_valid;
   logic [15:0] p_seg;
   logic [7:0]  p_pcin;

   always @(negedge clk) begin
      if (rst) begin
         exp_addr   = RST_PC;
         flush_pend = 1'b0;
         have_prev  = 1'b0;
         redir_q.delete();
      end else begin
         if (flush_pend) begin
            chk("flush_segment", 32'(segment), 32'(NOP));
            chk("flush_seg_valid", 32'(seg_valid), 32'd0);
         end else if (have_prev && p_stall) begin
            chk("stall_hold_segment", 32'(segment), 32'(p_seg));
            chk("stall_hold_pc_in", 32'(PC_in), 32'(p_pcin));
            chk("stall_hold_valid", 32'(seg_valid), 32'(p_valid));
         end else if (seg_valid && !(have_prev && p_valid && segment == p_seg && PC_in == p_pcin)) begin
            chk("instr_pc_in", 32'(PC_in), 32'((int'(exp_addr) + 1) % 256));
            chk("instr_word", 32'(segment), 32'(mem[exp_addr]));
            exp_addr = 8'((int'(exp_addr) + 1) % 256);
            n_instr++;
         end
         if (L_PC) begin
            if (redir_q.size() == 0) fail_now("redirect_queue_empty");
            else exp_addr = redir_q.pop_front();
         end
         flush_pend = L_PC;
         p_stall    = stall;
         p_valid    = seg_valid;
         p_seg      = segment;
         p_pcin     = PC_in;
         have_prev  = 1'b1;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_checks();
      chk("rst_imem_req", 32'(imem_req), 32'd0);
      chk("rst_imem_addr", 32'(imem_addr), 32'(RST_PC));
      chk("rst_segment", 32'(segment), 32'(NOP));
      chk("rst_pc_in", 32'(PC_in), 32'(RST_PC));
      chk("rst_seg_valid", 32'(seg_valid), 32'd0);
   endtask

   // Waits (bounded) until an instruction is shown; returns with outputs sampled.
   task automatic wait_seg(string name);
      bit got = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (seg_valid === 1'b1) begin
            got = 1;
            break;
         end
         cyc();
      end
      if (!got) fail_now(name);
   endtask

   task automatic wait_req(string name);
      bit got = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (imem_req === 1'b1) begin
            got = 1;
            break;
         end
         cyc();
      end
      if (!got) fail_now(name);
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; L_PC = 1'b0; S11 = 1'b0; S10 = 1'b0;
      OR2 = 8'h00; NPC_in = 8'h00; dm_data = 8'h00;
      imem_valid = 1'b0; imem_rdata = 16'h0000;
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      mem[0] = 16'h1234; mem[1] = 16'hBEEF; mem[2] = 16'h5A07;
      lat_fix = 1;

      repeat (3) cyc();
      @(negedge clk);
      reset_checks();

      // Reset release and first fetches with 1-cycle memory.
      cyc(); rst = 1'b0;
      @(negedge clk);
      chk("c1_req", 32'(imem_req), 32'd1);
      chk("c1_addr", 32'(imem_addr), 32'h00);
      cyc(); @(negedge clk);
      chk("c2_req", 32'(imem_req), 32'd0);
      cyc(); @(negedge clk);
      chk("c3_segment", 32'(segment), 32'h1234);
      chk("c3_pc_in", 32'(PC_in), 32'h01);
      chk("c3_seg_valid", 32'(seg_valid), 32'd1);
      chk("c3_req", 32'(imem_req), 32'd1);
      chk("c3_addr", 32'(imem_addr), 32'h01);
      cyc();
      cyc(); @(negedge clk);
      chk("c5_req", 32'(imem_req), 32'd1);
      chk("c5_addr", 32'(imem_addr), 32'h02);

      // Response lands while stalled for 3 cycles.
      cyc(); stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         cyc(); @(negedge clk);
         chk("stall_segment", 32'(segment), 32'hBEEF);
         chk("stall_no_req", 32'(imem_req), 32'd0);
      end
      cyc(); stall = 1'b0;
      @(negedge clk);
      chk("unstall_segment_old", 32'(segment), 32'hBEEF);
      cyc(); @(negedge clk);
      chk("skid_segment", 32'(segment), 32'h5A07);
      chk("skid_seg_valid", 32'(seg_valid), 32'd1);
      chk("skid_req", 32'(imem_req), 32'd1);
      chk("skid_addr", 32'(imem_addr), 32'h03);

      // Relative redirect with wrap, taken in ISSUE.
      cyc();
      cyc(); do_redirect(2'b01, 8'hF0, 8'h20, 8'h00);
      cyc(); L_PC = 1'b0; lat_fix = 3;
      @(negedge clk);
      chk("rel_addr", 32'(imem_addr), 32'h10);
      chk("rel_req", 32'(imem_req), 32'd1);
      chk("rel_segment", 32'(segment), 32'(NOP));
      chk("rel_seg_valid", 32'(seg_valid), 32'd0);

      // Return-address redirect while waiting on 3-cycle memory.
      cyc(); do_redirect(2'b10, 8'h00, 8'h00, 8'h3C);
      cyc(); L_PC = 1'b0;
      @(negedge clk);
      chk("drop_req_idle", 32'(imem_req), 32'd0);
      cyc(); @(negedge clk);
      chk("drop_req_idle2", 32'(imem_req), 32'd0);
      chk("drop_not_shown", 32'(seg_valid), 32'd0);
      cyc(); lat_fix = 1;
      @(negedge clk);
      chk("drop_req", 32'(imem_req), 32'd1);
      chk("drop_addr", 32'(imem_addr), 32'h3C);
      wait_seg("drop_wait_segment");
      chk("drop_pc_in", 32'(PC_in), 32'h3D);
      chk("drop_segment", 32'(segment), 32'(mem[8'h3C]));

      // Sequential fetch across the 8'hFF boundary.
      cyc(); do_redirect(2'b11, 8'h00, 8'hFF, 8'h00);
      cyc(); L_PC = 1'b0;
      wait_seg("wrap_wait_segment");
      chk("wrap_pc_in", 32'(PC_in), 32'h00);
      chk("wrap_segment", 32'(segment), 32'(mem[8'hFF]));
      chk("wrap_req", 32'(imem_req), 32'd1);
      chk("wrap_addr", 32'(imem_addr), 32'h00);

      // Reset in WAIT with the response arriving during reset.
      cyc(); lat_fix = 2;
      wait_req("rst_wait_req");
      cyc(); rst = 1'b1;
      cyc();
      cyc(); @(negedge clk);
      reset_checks();
      cyc(); rst = 1'b0; lat_fix = 1;
      @(negedge clk);
      chk("refetch_req", 32'(imem_req), 32'd1);
      chk("refetch_addr", 32'(imem_addr), 32'(RST_PC));
      wait_seg("refetch_wait_segment");
      chk("refetch_pc_in", 32'(PC_in), 32'h01);
      chk("refetch_segment", 32'(segment), 32'h1234);

      // Random stalls, redirects and memory latency.
      lat_fix = 0;
      for (int i = 0; i < 2000; i++) begin
         cyc();
         stall = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 11) == 0)
            do_redirect(2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
         else
            L_PC = 1'b0;
      end
      cyc(); L_PC = 1'b0; stall = 1'b0;
      repeat (20) cyc();
      @(negedge clk);
      chk("progress", 32'(n_instr > 100), 32'd1);
      chk("redirects_consumed", 32'(redir_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 8'h00, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter NOP_WORD, default 16'h0000, giving the instruction word driven on flush.
REQ-003 The block SHALL have one clock and a synchronous active-high reset.
REQ-004 Ports SHALL be exactly as follows (name, direction, width, meaning):
- clk  in  1  sole clock; all state changes on posedge.
- rst  in  1  synchronous active-high reset.
- imem_req  out  1  single-cycle fetch request pulse.
- imem_addr  out  8  fetch address; valid while imem_req=1.
- imem_valid  in  1  single-cycle response strobe, at least 1 cycle after imem_req.
- imem_rdata  in  16  instruction word; valid with imem_valid.
- stall  in  1  downstream hold: freeze segment/PC_in.
- L_PC  in  1  PC redirect from control generator.
- S11, S10  in  1 each  redirect source select.
- OR2  in  8  operand byte of the redirecting instruction.
- NPC_in  in  8  next-PC of the redirecting instruction.
- dm_data  in  8  data-memory read data (return address).
- segment  out  16  instruction word to decode stage; [15:8] opcode, [7:0] operand.
- PC_in  out  8  address of segment + 1, modulo 256.
- seg_valid  out  1  segment holds a real (non-flushed) instruction.

Function
REQ-005 The block SHALL keep at most one imem request outstanding.
REQ-006 FSM states SHALL be ISSUE, WAIT, HOLD and DROP.
- ISSUE: imem_req=1, imem_addr=pc; go to WAIT next cycle.
- WAIT: on imem_valid with stall=0, load segment<=imem_rdata, PC_in<=pc+1, seg_valid<=1, pc<=pc+1, and go to ISSUE.
- WAIT: on imem_valid with stall=1, capture imem_rdata in a one-entry skid register and go to HOLD.
- HOLD: when stall=0, move the skid entry to segment/PC_in and go to ISSUE.
- DROP: wait for the pending imem_valid, discard its data, then go to ISSUE.
REQ-007 Steady-state throughput SHALL be one instruction per (memory latency + 1) cycles; with 1-cycle memory, imem_req SHALL pulse every 2 cycles.
REQ-008 While stall=1, segment, PC_in and seg_valid SHALL hold their values, and no new request SHALL issue from HOLD.
REQ-009 L_PC=1 SHALL load pc with a target chosen by {S11,S10}:
- 01: NPC_in+OR2, 8-bit modulo-256 unsigned add.
- 11: OR2.
- 10: dm_data.
- 00: NPC_in.
REQ-010 On the cycle after L_PC=1, segment SHALL be NOP_WORD and seg_valid SHALL be 0, regardless of stall.
REQ-011 On L_PC=1, the skid entry SHALL be discarded.
REQ-012 On L_PC=1, the next state SHALL depend on the current state:
- From ISSUE or HOLD: go to ISSUE, so the next cycle requests the target.
- From WAIT without imem_valid in the same cycle: go to DROP.
- From WAIT with imem_valid in the same cycle: discard the response and go to ISSUE.
REQ-013 L_PC SHALL take priority over stall and over imem_valid.
REQ-014 pc+1 SHALL wrap from 8'hFF to 8'h00 with no flag.
REQ-015 imem_valid arriving in ISSUE or HOLD is a protocol violation; the block SHALL ignore it.

Reset
REQ-016 While rst=1, the block SHALL force:
- state=ISSUE, pc=RESET_PC
- imem_req=0, imem_addr=RESET_PC
- segment=NOP_WORD, PC_in=RESET_PC, seg_valid=0
- skid register empty.
REQ-017 The first imem_req pulse SHALL occur in the first cycle after rst deasserts, with imem_addr=RESET_PC.
REQ-018 Reset asserted mid-fetch SHALL abandon the outstanding request; a later imem_valid SHALL be ignored unless the block is in WAIT for a new request.

Verification
REQ-019 Reset release with 1-cycle memory returning 16'h1234 at address 0 -> imem_req at cycle 1 with imem_addr=00; at cycle 3 segment=1234, PC_in=01, seg_valid=1; next request has imem_addr=01.
REQ-020 Memory returns 16'h5A07 while stall=1, stall held 3 cycles -> segment unchanged and no imem_req during the stall; one cycle after stall falls, segment=5A07 and a request issues.
REQ-021 L_PC=1, {S11,S10}=01, NPC_in=8'hF0, OR2=8'h20 -> next imem_addr=8'h10 (wrap); segment=0000, seg_valid=0 on the following cycle.
REQ-022 L_PC=1, {S11,S10}=10, dm_data=8'h3C while in WAIT with a 3-cycle memory -> pending response discarded (never on segment); next imem_addr=3C.
REQ-023 Sequential fetch from pc=8'hFF -> PC_in=00 and next imem_addr=00.
REQ-024 rst asserted in WAIT, imem_valid arrives 1 cycle later -> data ignored; outputs at reset values; refetch from RESET_PC.
